alu_src_stage: RTL and testbench

Registered, parametrised successor to the ALU operand-B selector in the MIPS datapath. It sits on the ID/EX boundary and picks operand B from register, immediate, shift amount or a forced constant. It bypasses the register operand from the EX/MEM and MEM/WB stages and holds the result in a two-entry valid/ready elastic buffer, so the EX stage can stall without losing operands.

---
 rtl/alu_src_stage_pkg.sv | 23 ++
 rtl/alu_src_stage_if.sv | 47 ++++
 rtl/alu_src_stage_select.sv | 72 +++++++
 rtl/alu_src_stage.sv | 112 +++++++++++
 tb/tb_alu_src_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_src_stage_pkg.sv
// Shared types for the ALU operand-B stage: source codes, buffer states and defaults.
// Forwarding is built only when ALU_SRC_FWD_EN is defined.
package alu_src_pkg;

  typedef enum logic [2:0] {
    SRC_REG     = 3'd0,
    SRC_FWD_EXM = 3'd1,
    SRC_FWD_MWB = 3'd2,
    SRC_IMM     = 3'd3,
    SRC_SHAMT   = 3'd4,
    SRC_ZERO    = 3'd5,
    SRC_SYSC    = 3'd6
  } src_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_SYSCALL_CODE = 10;

endpackage

// File: rtl/alu_src_stage_if.sv
// ID-side operand offer, writeback candidates and EX-side valid/ready result bundle.
// master drives operands (ID/EX side), slave is the operand-B stage.
interface alu_src_stage_if
  import alu_src_pkg::*;
#(
  parameter int W  = 32,
  parameter int RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  r2;
  logic [W-1:0]  extend;
  logic [W-1:0]  shift_num;
  logic [RW-1:0] rt_addr;
  logic          alu_src;
  logic          shift;
  logic          com_branch;
  logic          syscall;
  logic          exm_we;
  logic [RW-1:0] exm_addr;
  logic [W-1:0]  exm_data;
  logic          mwb_we;
  logic [RW-1:0] mwb_addr;
  logic [W-1:0]  mwb_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  src_e          y_src;

  modport master (
    output in_valid, r2, extend, shift_num, rt_addr,
    output alu_src, shift, com_branch, syscall,
    output exm_we, exm_addr, exm_data, mwb_we, mwb_addr, mwb_data,
    output flush, out_ready,
    input  in_ready, out_valid, y, y_src
  );

  modport slave (
    input  in_valid, r2, extend, shift_num, rt_addr,
    input  alu_src, shift, com_branch, syscall,
    input  exm_we, exm_addr, exm_data, mwb_we, mwb_addr, mwb_data,
    input  flush, out_ready,
    output in_ready, out_valid, y, y_src
  );

endinterface

// File: rtl/alu_src_stage_select.sv
// Combinational operand-B choice: register bypass then priority select.
// Bypass from EX/MEM and MEM/WB exists only when ALU_SRC_FWD_EN is defined.
module alu_src_select
  import alu_src_pkg::*;
#(
  parameter int          W            = 32,
  parameter int          RW           = 5,
  parameter int unsigned SYSCALL_CODE = DEFAULT_SYSCALL_CODE
) (
  input  logic [W-1:0]  r2_i,
  input  logic [W-1:0]  extend_i,
  input  logic [W-1:0]  shift_num_i,
  input  logic [RW-1:0] rt_addr_i,
  input  logic          alu_src_i,
  input  logic          shift_i,
  input  logic          com_branch_i,
  input  logic          syscall_i,
  input  logic          exm_we_i,
  input  logic [RW-1:0] exm_addr_i,
  input  logic [W-1:0]  exm_data_i,
  input  logic          mwb_we_i,
  input  logic [RW-1:0] mwb_addr_i,
  input  logic [W-1:0]  mwb_data_i,
  output logic [W-1:0]  value_o,
  output src_e          src_o
);

  localparam logic [W-1:0] SYSC_VAL = W'(SYSCALL_CODE);

  logic [W-1:0] reg_val;
  src_e         reg_src;

`ifdef ALU_SRC_FWD_EN
  // Register 0 is hardwired, so a pending write to it must never bypass.
  always_comb begin
    reg_val = r2_i;
    reg_src = SRC_REG;
    if (rt_addr_i != '0 && exm_we_i && exm_addr_i == rt_addr_i) begin
      reg_val = exm_data_i;
      reg_src = SRC_FWD_EXM;
    end else if (rt_addr_i != '0 && mwb_we_i && mwb_addr_i == rt_addr_i) begin
      reg_val = mwb_data_i;
      reg_src = SRC_FWD_MWB;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rt_addr_i, exm_we_i, exm_addr_i, exm_data_i,
                        mwb_we_i, mwb_addr_i, mwb_data_i};
  assign reg_val    = r2_i;
  assign reg_src    = SRC_REG;
`endif

  always_comb begin
    value_o = reg_val;
    src_o   = reg_src;
    if (syscall_i) begin
      value_o = SYSC_VAL;
      src_o   = SRC_SYSC;
    end else if (com_branch_i) begin
      value_o = '0;
      src_o   = SRC_ZERO;
    end else if (shift_i) begin
      value_o = shift_num_i;
      src_o   = SRC_SHAMT;
    end else if (alu_src_i) begin
      value_o = extend_i;
      src_o   = SRC_IMM;
    end
  end

endmodule

// File: rtl/alu_src_stage.sv
// Registered ALU operand-B stage with a two-entry (output + skid) elastic buffer.
// Define ALU_SRC_FWD_EN to enable EX/MEM and MEM/WB bypass of the rt operand.
module alu_src_stage
  import alu_src_pkg::*;
#(
  parameter int          W            = 32,
  parameter int          RW           = 5,
  parameter int unsigned SYSCALL_CODE = DEFAULT_SYSCALL_CODE
) (
  input  logic            clk,
  input  logic            rst,
  alu_src_stage_if.slave  bus
);

  state_e       state_q, state_d;
  logic [W-1:0] out_val_q, out_val_d;
  src_e         out_src_q, out_src_d;
  logic [W-1:0] skid_val_q, skid_val_d;
  src_e         skid_src_q, skid_src_d;

  logic [W-1:0] sel_val;
  src_e         sel_src;
  logic         accept;

  alu_src_select #(
    .W            (W),
    .RW           (RW),
    .SYSCALL_CODE (SYSCALL_CODE)
  ) u_select (
    .r2_i         (bus.r2),
    .extend_i     (bus.extend),
    .shift_num_i  (bus.shift_num),
    .rt_addr_i    (bus.rt_addr),
    .alu_src_i    (bus.alu_src),
    .shift_i      (bus.shift),
    .com_branch_i (bus.com_branch),
    .syscall_i    (bus.syscall),
    .exm_we_i     (bus.exm_we),
    .exm_addr_i   (bus.exm_addr),
    .exm_data_i   (bus.exm_data),
    .mwb_we_i     (bus.mwb_we),
    .mwb_addr_i   (bus.mwb_addr),
    .mwb_data_i   (bus.mwb_data),
    .value_o      (sel_val),
    .src_o        (sel_src)
  );

  // Handshake flags decode registered state only; out_ready never reaches in_ready.
  assign bus.in_ready  = (state_q != ST_TWO);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.y         = out_val_q;
  assign bus.y_src     = out_src_q;

  assign accept = bus.in_valid && (state_q != ST_TWO) && !bus.flush;

  always_comb begin
    state_d    = state_q;
    out_val_d  = out_val_q;
    out_src_d  = out_src_q;
    skid_val_d = skid_val_q;
    skid_src_d = skid_src_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          out_val_d = sel_val;
          out_src_d = sel_src;
        end
      end
      ST_ONE: begin
        if (accept && !bus.out_ready) begin
          state_d    = ST_TWO;
          skid_val_d = sel_val;
          skid_src_d = sel_src;
        end else if (accept) begin
          out_val_d = sel_val;
          out_src_d = sel_src;
        end else if (bus.out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (bus.out_ready) begin
          state_d   = ST_ONE;
          out_val_d = skid_val_q;
          out_src_d = skid_src_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_val_q  <= '0;
      out_src_q  <= SRC_REG;
      skid_val_q <= '0;
      skid_src_q <= SRC_REG;
    end else begin
      state_q    <= state_d;
      out_val_q  <= out_val_d;
      out_src_q  <= out_src_d;
      skid_val_q <= skid_val_d;
      skid_src_q <= skid_src_d;
    end
  end

endmodule

// File: tb/tb_alu_src_stage.sv
// Scoreboard bench for alu_src_stage: reference model pushed on accept, compared on output.
module tb_alu_src_stage;
  import alu_src_pkg::*;

  typedef struct {
    logic [31:0] y;
    logic [2:0]  src;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  alu_src_stage_if #(.W(32), .RW(5)) bus ();

  alu_src_stage #(.W(32), .RW(5), .SYSCALL_CODE(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model();
    exp_t        e;
    logic [31:0] rv;
    logic [2:0]  rs;
    rv = bus.r2;
    rs = 3'd0;
`ifdef ALU_SRC_FWD_EN
    if (bus.rt_addr != 5'd0 && bus.exm_we && bus.exm_addr == bus.rt_addr) begin
      rv = bus.exm_data; rs = 3'd1;
    end else if (bus.rt_addr != 5'd0 && bus.mwb_we && bus.mwb_addr == bus.rt_addr) begin
      rv = bus.mwb_data; rs = 3'd2;
    end
`endif
    if (bus.syscall)         begin e.y = 32'd10;        e.src = 3'd6; end
    else if (bus.com_branch) begin e.y = 32'd0;         e.src = 3'd5; end
    else if (bus.shift)      begin e.y = bus.shift_num; e.src = 3'd4; end
    else if (bus.alu_src)    begin e.y = bus.extend;    e.src = 3'd3; end
    else                     begin e.y = rv;            e.src = rs;   end
    return e;
  endfunction

  // Model state: out_valid iff something held, in_ready iff fewer than two held.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      check_val("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
      check_val("in_ready", 64'(bus.in_ready), 64'(sb.size() < 2));
      if (bus.out_valid && sb.size() != 0) begin
        check_val("y", 64'(bus.y), 64'(sb[0].y));
        check_val("y_src", 64'(bus.y_src), 64'(sb[0].src));
        if (bus.out_ready) begin
          $display("out y=0x%08h y_src=%0d t=%0t", bus.y, bus.y_src, $time);
          void'(sb.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model());
      if (bus.flush) sb.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] r2, input logic [31:0] ext,
                        input logic [31:0] sh, input logic [4:0] rt, input logic as,
                        input logic shf, input logic cb, input logic sc);
    bus.in_valid   = v;
    bus.r2         = r2;
    bus.extend     = ext;
    bus.shift_num  = sh;
    bus.rt_addr    = rt;
    bus.alu_src    = as;
    bus.shift      = shf;
    bus.com_branch = cb;
    bus.syscall    = sc;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                         input logic mw, input logic [4:0] ma, input logic [31:0] md);
    bus.exm_we   = ew;
    bus.exm_addr = ea;
    bus.exm_data = ed;
    bus.mwb_we   = mw;
    bus.mwb_addr = ma;
    bus.mwb_data = md;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_y", 64'(bus.y), 64'd0);
    check_val("rst_y_src", 64'(bus.y_src), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    step();
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Priority ladder
    bus.out_ready = 1'b1;
    set_in(1, 32'd5, 32'd3, 32'd9, 5'd3, 1, 1, 1, 1); step();
    set_in(1, 32'd5, 32'd3, 32'd9, 5'd3, 1, 1, 1, 0); step();
    set_in(1, 32'd5, 32'd3, 32'd7, 5'd3, 1, 1, 0, 0); step();
    set_in(1, 32'd5, 32'h1234, 32'd7, 5'd3, 1, 0, 0, 0); step();
    set_in(1, 32'd5, 32'h1234, 32'd7, 5'd3, 0, 0, 0, 0); step();

    // Forwarding
    set_fwd(1, 5'd8, 32'hAA, 1, 5'd8, 32'hBB);
    set_in(1, 32'd1, 32'd0, 32'd0, 5'd8, 0, 0, 0, 0); step();
    set_fwd(0, 5'd8, 32'hAA, 1, 5'd8, 32'hBB); step();
    set_fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
    set_in(1, 32'd1, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0); step();
    set_fwd(1, 5'd9, 32'hCC, 0, 5'd8, 32'hBB);
    set_in(1, 32'd2, 32'd0, 32'd0, 5'd8, 0, 0, 0, 0); step();
    set_fwd(0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0; step(); step();

    // Backpressure A,B accepted, C held until a slot frees
    bus.out_ready = 1'b0;
    set_in(1, 32'hA, 0, 0, 5'd1, 0, 0, 0, 0); step();
    set_in(1, 32'hB, 0, 0, 5'd1, 0, 0, 0, 0); step();
    set_in(1, 32'hC, 0, 0, 5'd1, 0, 0, 0, 0); step();
    check_val("bp_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    bus.out_ready = 1'b1; step();
    check_val("bp_in_ready_rise", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0; step(); step();

    // Flush while full, with an input offered in the same cycle
    bus.out_ready = 1'b0;
    set_in(1, 32'h11, 0, 0, 5'd1, 0, 0, 0, 0); step();
    set_in(1, 32'h22, 0, 0, 5'd1, 0, 0, 0, 0); step();
    set_in(1, 32'h33, 0, 0, 5'd1, 0, 0, 0, 0);
    bus.flush = 1'b1; step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check_val("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("flush_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1; step(); step();

    // Async reset mid-cycle while one entry is held
    bus.out_ready = 1'b0;
    set_in(1, 32'h44, 0, 0, 5'd1, 0, 0, 0, 0); step();
    bus.in_valid = 1'b0;
    check_val("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check_val("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("arst_y", 64'(bus.y), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    step();
    bus.out_ready = 1'b1;
    set_in(1, 32'h55, 0, 0, 5'd1, 0, 0, 0, 0); step();
    bus.in_valid = 1'b0;
    check_val("post_rst_y", 64'(bus.y), 64'h55);
    step(); step();

    // Random traffic with random backpressure and occasional flush
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      set_in(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 31),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0),
             1'($urandom_range(0, 8) == 0));
      set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      bus.flush = ($urandom_range(0, 15) == 0);
      step();
    end
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step(); step(); step();
    check_val("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
